// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, optional skid entry and
// synchronous flush. Carries an arbitrary-width stage bundle between CPU stages.
module pipe_stage_reg #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    parameter bit               SKID        = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       level
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FULL    = 2'd1,
        SKIDDED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_take;

    assign w_accept = in_valid & w_in_ready;
    assign w_take   = (r_state != EMPTY) & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= EMPTY;
        else     r_state <= w_state_nxt;
    end

    // Flush wins over everything; a SKIDDED state is unreachable when SKID=0
    // because in_ready follows out_ready there.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY:   if (w_accept) w_state_nxt = FULL;
                FULL: begin
                    if (w_take && !w_accept)              w_state_nxt = EMPTY;
                    else if (!w_take && w_accept && SKID) w_state_nxt = SKIDDED;
                end
                SKIDDED: if (w_take) w_state_nxt = FULL;
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = (r_state != EMPTY);
        level     = r_state;
        in_ready  = w_in_ready;
        out_data  = r_main;
    end

    // Loads are suppressed during flush so out_data keeps its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main <= RESET_VALUE;
            r_skid <= RESET_VALUE;
        end else if (!flush) begin
            case (r_state)
                EMPTY: if (w_accept) r_main <= in_data;
                FULL: begin
                    if (w_take && w_accept)       r_main <= in_data;
                    else if (!w_take && w_accept) r_skid <= in_data;
                end
                SKIDDED: if (w_take) r_main <= r_skid;
                default: ;
            endcase
        end
    end

    generate
        if (SKID) begin : g_skid
            logic r_in_ready;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_in_ready <= 1'b1;
                else     r_in_ready <= (w_state_nxt != SKIDDED);
            end
            assign w_in_ready = r_in_ready;
        end else begin : g_noskid
            assign w_in_ready = (r_state == EMPTY) | out_ready;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance, each checked
// against a queue model, plus directed vectors for handshake corner cases.
module tb_pipe_stage_reg;
    localparam int          W  = 32;
    localparam logic [31:0] RV = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          f1 = 0, iv1 = 0, or1 = 0, ir1, ov1;
    logic [W-1:0]  d1 = 0, od1;
    logic [1:0]    lv1;
    logic          f0 = 0, iv0 = 0, or0 = 0, ir0, ov0;
    logic [W-1:0]  d0 = 0, od0;
    logic [1:0]    lv0;

    pipe_stage_reg #(.WIDTH(W), .RESET_VALUE(RV), .SKID(1'b1)) u1 (
        .clk(clk), .rst(rst), .flush(f1), .in_valid(iv1), .in_ready(ir1),
        .in_data(d1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .level(lv1));

    pipe_stage_reg #(.WIDTH(W), .RESET_VALUE(RV), .SKID(1'b0)) u0 (
        .clk(clk), .rst(rst), .flush(f0), .in_valid(iv0), .in_ready(ir0),
        .in_data(d0), .out_valid(ov0), .out_ready(or0), .out_data(od0), .level(lv0));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: a FIFO of capacity 2 (SKID=1) or 1 (SKID=0) with flush.
    logic [W-1:0] q1[$];
    logic [W-1:0] q0[$];
    bit m_a1, m_t1, m_a0, m_t0;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        ev;
        logic        er;
        logic [1:0]  el;
        logic [31:0] ed;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input logic fl, input logic iv, input logic [31:0] d,
                                input logic ordy, input logic ev, input logic er,
                                input logic [1:0] el, input logic [31:0] ed);
        vec_t v;
        v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.ev = ev; v.er = er; v.el = el; v.ed = ed;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0d: got %h, want %h", name, idx, act, exp);
        end
    endtask

    task automatic sample(input int idx);
        bit rdy1, rdy0;
        @(negedge clk);
        rdy1 = (q1.size() < 2);
        rdy0 = (q0.size() == 0) || or0;
        m_a1 = iv1 && rdy1;
        m_t1 = (q1.size() != 0) && or1;
        m_a0 = iv0 && rdy0;
        m_t0 = (q0.size() != 0) && or0;
        chk("u1_valid", idx, 32'(ov1), 32'(q1.size() != 0));
        chk("u1_level", idx, 32'(lv1), 32'(q1.size()));
        chk("u1_ready", idx, 32'(ir1), 32'(rdy1));
        if (q1.size() != 0) chk("u1_data", idx, od1, q1[0]);
        chk("u0_valid", idx, 32'(ov0), 32'(q0.size() != 0));
        chk("u0_level", idx, 32'(lv0), 32'(q0.size()));
        chk("u0_ready", idx, 32'(ir0), 32'(rdy0));
        if (q0.size() != 0) chk("u0_data", idx, od0, q0[0]);
    endtask

    task automatic advance();
        @(posedge clk);
        if (f1) q1.delete();
        else begin
            if (m_t1) void'(q1.pop_front());
            if (m_a1) q1.push_back(d1);
        end
        if (f0) q0.delete();
        else begin
            if (m_t0) void'(q0.pop_front());
            if (m_a0) q0.push_back(d0);
        end
        #1;
    endtask

    task automatic chk_reset(input int idx);
        chk("rst_valid1", idx, 32'(ov1), 32'd0);
        chk("rst_level1", idx, 32'(lv1), 32'd0);
        chk("rst_ready1", idx, 32'(ir1), 32'd1);
        chk("rst_data1",  idx, od1, RV);
        chk("rst_valid0", idx, 32'(ov0), 32'd0);
        chk("rst_level0", idx, 32'(lv0), 32'd0);
        chk("rst_ready0", idx, 32'(ir0), 32'd1);
        chk("rst_data0",  idx, od0, RV);
    endtask

    initial begin
        // Reset values must appear before any clock edge.
        #1 rst = 1'b1;
        #1 chk_reset(0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed vectors on the skid instance; the SKID=0 instance idles.
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 1, 32'h10 + 32'(i), 1, i > 0, 1, (i > 0) ? 2'd1 : 2'd0,
                             32'h10 + 32'(i) - 32'd1));
        tbl.push_back(mk(0, 0, 0,     1, 1, 1, 1, 32'h17));
        tbl.push_back(mk(0, 0, 0,     1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'hA1,  1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'hA2,  0, 1, 1, 1, 'hA1));
        tbl.push_back(mk(0, 1, 'hA3,  0, 1, 0, 2, 'hA1));
        tbl.push_back(mk(0, 1, 'hA3,  1, 1, 0, 2, 'hA1));
        tbl.push_back(mk(0, 1, 'hA3,  1, 1, 1, 1, 'hA2));
        tbl.push_back(mk(0, 0, 0,     1, 1, 1, 1, 'hA3));
        tbl.push_back(mk(0, 0, 0,     0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'hB1,  0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'hB2,  0, 1, 1, 1, 'hB1));
        tbl.push_back(mk(1, 1, 'hB3,  0, 1, 0, 2, 'hB1));
        tbl.push_back(mk(1, 1, 'hB3,  0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'hC1,  0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 'hC2,  1, 1, 1, 1, 'hC1));
        tbl.push_back(mk(0, 0, 0,     1, 0, 1, 0, 0));

        foreach (tbl[i]) begin
            f1 = tbl[i].fl; iv1 = tbl[i].iv; d1 = tbl[i].d; or1 = tbl[i].ordy;
            sample(100 + i);
            chk("tbl_valid", i, 32'(ov1), 32'(tbl[i].ev));
            chk("tbl_ready", i, 32'(ir1), 32'(tbl[i].er));
            chk("tbl_level", i, 32'(lv1), 32'(tbl[i].el));
            if (tbl[i].ev) chk("tbl_data", i, od1, tbl[i].ed);
            advance();
        end
        f1 = 0; iv1 = 0; or1 = 0;

        // Combinational-ready mode: stall, then take and load in one cycle.
        iv0 = 1; d0 = 32'h55; or0 = 0;
        sample(200); chk("s0_ready_empty", 0, 32'(ir0), 32'd1); advance();
        iv0 = 0; or0 = 0;
        sample(201); chk("s0_ready_stall", 1, 32'(ir0), 32'd0);
        chk("s0_data_held", 1, od0, 32'h55); advance();
        iv0 = 1; d0 = 32'h66; or0 = 1;
        sample(202); chk("s0_ready_pass", 2, 32'(ir0), 32'd1);
        chk("s0_data_taken", 2, od0, 32'h55); advance();
        iv0 = 0; or0 = 0;
        sample(203); chk("s0_level", 3, 32'(lv0), 32'd1);
        chk("s0_data_loaded", 3, od0, 32'h66); advance();
        or0 = 1;
        sample(204); advance();

        // Random traffic with occasional flush and one mid-stream reset.
        for (int i = 0; i < 10000; i++) begin
            iv1 = ($urandom_range(0, 2) != 0); or1 = ($urandom_range(0, 2) != 0);
            f1  = ($urandom_range(0, 99) < 5); d1 = $urandom;
            iv0 = ($urandom_range(0, 2) != 0); or0 = ($urandom_range(0, 2) != 0);
            f0  = ($urandom_range(0, 99) < 5); d0 = $urandom;
            if (i == 5000) begin
                rst = 1'b1;
                #1 chk_reset(i);
                @(posedge clk);
                #1 chk_reset(i + 1);
                rst = 1'b0;
                q1.delete();
                q0.delete();
            end
            sample(1000 + i);
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register with a valid/ready handshake, an optional skid buffer and synchronous flush. It generalises the plain enable register: instead of a bare EN, each stage carries a valid bit, produces back-pressure, and can be killed by a branch or exception flush. It sits between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and carries an arbitrary-width stage bundle.

## Interface
- WIDTH, 32: payload width in bits.
- RESET_VALUE, {WIDTH{1'b0}}: value loaded into both data registers on reset.
- SKID, 1: 1 adds a second entry so in_ready is a register output; 0 is a single entry whose in_ready depends combinationally on out_ready.

- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  stage can accept this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  payload held in the main register.
- level  output  2  number of held entries: 0, 1 or 2.

## Operation
- Transfers: accept = in_valid & in_ready; take = out_valid & out_ready.
- Storage: main register (drives out_data) and skid register (SKID=1 only).
- States: EMPTY (level 0), FULL (level 1), SKIDDED (level 2, SKID=1 only).
- EMPTY
  - accept: main <= in_data, go to FULL.
  - No accept: stay in EMPTY.
- FULL
  - take & accept: main <= in_data, stay in FULL.
  - take & !accept: go to EMPTY.
  - !take & accept (SKID=1 only): skid <= in_data, go to SKIDDED.
  - !take & !accept: hold.
- SKIDDED
  - No accept is possible.
  - take: main <= skid, go to FULL.
  - !take: hold.
- in_ready
  - SKID=1: registered; equals (state != SKIDDED).
  - SKID=0: combinational; equals (state == EMPTY) | out_ready.
- out_valid = (state != EMPTY); level encodes the state.
- flush
  - Highest priority: state goes to EMPTY at the next edge regardless of accept or take.
  - An accept in the flush cycle is discarded. Upstream sees a completed handshake, and the data is dropped.
  - A take in the flush cycle completes normally downstream.
  - Data registers are not cleared by flush. out_data keeps its last value and is don't-care while out_valid is 0.
- Data never reorders: skid contents are always younger than main.
- No data is ever lost except by flush or rst.

## Timing
- Reset values, asserted immediately on rst and held until the first clk edge after rst deasserts:
  - out_valid 0, level 0, in_ready 1 (both modes).
  - main = skid = RESET_VALUE, so out_data = RESET_VALUE.
- Latency: data accepted at edge N is on out_data with out_valid=1 after edge N; it is presentable to downstream in cycle N+1.
- Throughput: one transfer per cycle sustained when out_ready is held high, in both modes.
- SKID=1
  - in_ready drops one cycle after the stall begins.
  - The single beat accepted in that cycle lands in skid.
  - in_ready reasserts the cycle after the take that moves skid into main.
- SKID=0: combinational path from out_ready to in_ready. Used only where that path is acceptable timing-wise.
- Simultaneous flush and rst: rst dominates.
- rst mid-transfer: all entries are lost and outputs take their reset values immediately.
- Back-to-back flush cycles: state stays EMPTY and in_ready stays 1.

## Test plan
- Reset/idle
  - Stimulus: hold rst=1 mid-traffic with RESET_VALUE=32'hDEAD_BEEF.
  - Required: out_valid=0, level=0, in_ready=1 and out_data=32'hDEAD_BEEF asynchronously, before any clk edge.
- Streaming
  - Stimulus: out_ready=1, present 8 beats 0x10..0x17 on consecutive cycles.
  - Required: out_data 0x10..0x17 on 8 consecutive cycles, each one cycle after acceptance, with no bubbles.
- Skid stall (SKID=1)
  - Stimulus: stream 0xA1, 0xA2, 0xA3 and drop out_ready in the cycle after 0xA1 is accepted.
  - Required: level goes 1→2, in_ready goes 0, and 0xA3 is held upstream.
  - Stimulus continued: raise out_ready.
  - Required: outputs 0xA1, 0xA2, 0xA3 in order, with no loss and no duplicate.
- Combinational mode (SKID=0)
  - Stimulus: FULL with 0x55, out_ready=0.
  - Required: in_ready=0.
  - Stimulus continued: out_ready=1 with in_valid=1, data 0x66 in the same cycle.
  - Required: 0x55 is taken, 0x66 is loaded, and level stays 1.
- Flush
  - Stimulus: in SKIDDED (0xB1 in main, 0xB2 in skid), assert flush with in_valid=1, data 0xB3.
  - Required: next cycle out_valid=0, level=0, in_ready=1, and 0xB3 never appears at the output.
- Random
  - Stimulus: 10k cycles of random in_valid, out_ready and flush (5%), checked against a reference queue model.
  - Required: the output sequence matches the model, and level always equals the model's occupancy.
